cic_comp_fir: RTL and testbench
===============================

Name: cic_comp_fir

Overview:
- Droop-compensation FIR directly downstream of the CIC decimator; consumes the decimated sample stream (cic_out/valid_out) and flattens the CIC passband sinc droop.
- Symmetric odd-length FIR, time-multiplexed over a single pre-add/multiply/accumulate datapath: one sample occupies the datapath for (TAPS+1)/2 MAC cycles.
- Output is rounded and saturated back to the stream format, with per-sample overflow/underflow flags and a registered bypass path.

Parameters:
- DATA_WIDTH, 16, input/output sample width (signed).
- DATA_FRAC, 15, fractional bits of samples.
- COEFF_WIDTH, 18, signed coefficient width.
- COEFF_FRAC, 16, fractional bits of coefficients.
- TAPS, 7, filter length; odd, ≥3.
- H (local), (TAPS+1)/2, number of stored unique coefficients / MAC cycles.
- ACC_WIDTH (local), DATA_WIDTH+1+COEFF_WIDTH+$clog2(H), accumulator width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- valid_in  in  1  input sample strobe (from CIC valid_out).
- bypass  in  1  route fir_in to fir_out, filter disabled.
- fir_in  in  DATA_WIDTH  signed input sample.
- coeff_wr_en  in  1  coefficient write strobe.
- coeff_addr  in  $clog2(H)  coefficient index 0..H-1 (H-1 = centre tap).
- coeff_data  in  COEFF_WIDTH  signed coefficient value.
- fir_out  out  DATA_WIDTH  signed filtered sample.
- valid_out  out  1  one-cycle strobe per output sample.
- busy  out  1  high while the MAC sequence is running.
- overflow  out  1  positive saturation on the current output.
- underflow  out  1  negative saturation on the current output.
- overrun  out  1  one-cycle pulse when valid_in is dropped.

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values:
  - fir_out=0; valid_out, busy, overflow, underflow, overrun = 0.
  - Delay line x[0..TAPS-1] = 0; accumulator = 0; FSM = IDLE.
  - Coefficients load defaults c[0..3] = {-2048, 4096, -8192, 77824} (DC gain 1.0).
- FSM states:
  - IDLE: on valid_in && !bypass, shift fir_in into x[0] (x[k]←x[k-1]), clear acc, k←0, go MAC.
  - MAC (H cycles, k=0..H-1):
    - k<H-1: acc += (x[k]+x[TAPS-1-k])·c[k], pre-add sign-extended to DATA_WIDTH+1.
    - k=H-1: acc += x[H-1]·c[H-1] (centre tap, no pre-add).
    - After k=H-1, go ROUND.
  - ROUND (1 cycle): r = (acc + 2^(COEFF_FRAC-1)) >>> COEFF_FRAC (round half up), then saturate to DATA_WIDTH.
    - Register fir_out, overflow, underflow; pulse valid_out; go IDLE.
- busy=1 in MAC and ROUND.
- Latency: valid_out is high in the cycle following edge E+H+1, where E is the accepting edge. Max input rate is one sample per H+1 cycles; default H=4 gives 5 cycles.
- Overrun: valid_in while busy → sample dropped, delay line untouched, overrun pulses the next cycle, in-flight result unaffected.
- valid_in in the same cycle ROUND completes (busy still 1) is also dropped.
- Flags: overflow/underflow update only with valid_out; otherwise they hold.
- Bypass:
  - Asserted: fir_out←fir_in and valid_out←valid_in (1-cycle register); flags=0; FSM forced to IDLE, any in-flight sample aborted with no valid_out.
  - The delay line still shifts on valid_in, so history is current on exit.
  - overrun is never raised in bypass.
- Coefficient writes:
  - Accepted only when FSM=IDLE and valid_in=0; take effect on the next sample.
  - Writes otherwise are ignored.
  - coeff_addr ≥ H is ignored.
  - Coefficients are not reset by anything except rst_n.
- Reset mid-MAC: all state cleared immediately; no valid_out after release until a new sample completes.
- Arithmetic is signed throughout. The accumulator cannot overflow at ACC_WIDTH; only the final narrowing saturates.

Test Plan:
- Reset then 7 samples of 0x4000 spaced 5 cycles → last output 0x4000, overflow=underflow=0; valid_out exactly 5 cycles after each accept edge.
- Impulse 0x4000 followed by zeros (defaults) → outputs -512, 1024, -2048, 19456, -2048, 1024, -512.
- Impulse 0x7FFF → 4th output saturates to 0x7FFF with overflow=1; the other taps give -1024, 2048, -4096 (rounding check). Impulse 0x8000 → 4th output 0x8000 with underflow=1.
- Back-to-back valid_in on consecutive cycles → second sample dropped, overrun pulse; first output unchanged. Also valid_in during ROUND → dropped.
- Write c[3]=65536 and c[0..2]=0 while idle, then impulse 0x1234 → output 0x1234 at centre delay only. Write attempted while busy → ignored, defaults retained.
- Assert bypass mid-MAC → no filtered valid_out, fir_out follows fir_in with 1-cycle latency. Deassert bypass, then apply 0x4000 DC → output immediately 0x4000, since the history was kept current. Pulse rst_n low mid-MAC → all outputs 0.

Source files
------------

// File: rtl/cic_comp_fir.sv
// Symmetric odd-length droop-compensation FIR behind the CIC decimator, time-multiplexed over one pre-add/MAC datapath.
// valid_out follows the accepting edge by H+1 cycles; samples arriving while busy are dropped and flagged with overrun.
module cic_comp_fir #(
    parameter int  DATA_WIDTH  = 16,
    parameter int  DATA_FRAC   = 15,
    parameter int  COEFF_WIDTH = 18,
    parameter int  COEFF_FRAC  = 16,
    parameter int  TAPS        = 7,
    localparam int H           = (TAPS + 1) / 2,
    localparam int AW          = $clog2(H),
    localparam int ACC_WIDTH   = DATA_WIDTH + 1 + COEFF_WIDTH + $clog2(H)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_in,
    input  logic                          bypass,
    input  logic signed [DATA_WIDTH-1:0]  fir_in,
    input  logic                          coeff_wr_en,
    input  logic [AW-1:0]                 coeff_addr,
    input  logic signed [COEFF_WIDTH-1:0] coeff_data,
    output logic signed [DATA_WIDTH-1:0]  fir_out,
    output logic                          valid_out,
    output logic                          busy,
    output logic                          overflow,
    output logic                          underflow,
    output logic                          overrun
);

    localparam int XW = $clog2(TAPS);
    localparam int PW = DATA_WIDTH + 1 + COEFF_WIDTH;
    // Products carry DATA_FRAC+COEFF_FRAC fraction bits; the output keeps DATA_FRAC of them.
    localparam int SHIFT = DATA_FRAC + COEFF_FRAC - DATA_FRAC;
    localparam logic signed [ACC_WIDTH-1:0] RND_HALF = ACC_WIDTH'(1) <<< (SHIFT - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX  = ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN  = -SAT_MAX - ACC_WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND} state_t;

    function automatic logic signed [COEFF_WIDTH-1:0] default_coeff(input int idx);
        logic signed [COEFF_WIDTH-1:0] c;
        c = '0;
        if (H == 4) begin
            case (idx)
                0:       c = COEFF_WIDTH'(-2048);
                1:       c = COEFF_WIDTH'(4096);
                2:       c = COEFF_WIDTH'(-8192);
                default: c = COEFF_WIDTH'(77824);
            endcase
        end else if (idx == H - 1) begin
            c = COEFF_WIDTH'(1) <<< COEFF_FRAC;
        end
        return c;
    endfunction

    state_t                          state_q;
    logic [AW-1:0]                   k_q;
    logic signed [ACC_WIDTH-1:0]     acc_q;
    logic signed [DATA_WIDTH-1:0]    x_q     [TAPS];
    logic signed [COEFF_WIDTH-1:0]   coeff_q [H];
    logic signed [DATA_WIDTH-1:0]    fir_out_q;
    logic                            valid_out_q, overflow_q, underflow_q, overrun_q;

    logic [XW-1:0]                   tap_idx, mirror_idx;
    logic signed [DATA_WIDTH:0]      pre_add;
    logic signed [PW-1:0]            product;
    logic signed [ACC_WIDTH-1:0]     acc_d, rnd_sum, rnd_val;
    logic signed [DATA_WIDTH-1:0]    sat_val;
    logic                            sat_hi, sat_lo;

    always_comb begin
        tap_idx    = XW'(k_q);
        mirror_idx = XW'(TAPS - 1) - tap_idx;
        // The centre tap has no mirror partner, so it skips the pre-add.
        if (k_q == AW'(H - 1)) begin
            pre_add = (DATA_WIDTH + 1)'(x_q[tap_idx]);
        end else begin
            pre_add = (DATA_WIDTH + 1)'(x_q[tap_idx]) + (DATA_WIDTH + 1)'(x_q[mirror_idx]);
        end
        product = PW'(pre_add) * PW'(coeff_q[k_q]);
        acc_d   = acc_q + ACC_WIDTH'(product);
        rnd_sum = acc_q + RND_HALF;
        rnd_val = rnd_sum >>> SHIFT;
        sat_hi  = rnd_val > SAT_MAX;
        sat_lo  = rnd_val < SAT_MIN;
        if (sat_hi) begin
            sat_val = SAT_MAX[DATA_WIDTH-1:0];
        end else if (sat_lo) begin
            sat_val = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            sat_val = rnd_val[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            fir_out_q   <= '0;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
            for (int i = 0; i < H; i++) coeff_q[i] <= default_coeff(i);
        end else begin
            valid_out_q <= 1'b0;
            overrun_q   <= 1'b0;
            // History also advances in bypass so filtering resumes without a fill transient.
            if (valid_in && (bypass || state_q == S_IDLE)) begin
                x_q[0] <= fir_in;
                for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
            end
            if (coeff_wr_en && !valid_in && state_q == S_IDLE && int'(coeff_addr) < H) begin
                coeff_q[coeff_addr] <= coeff_data;
            end
            if (bypass) begin
                state_q     <= S_IDLE;
                fir_out_q   <= fir_in;
                valid_out_q <= valid_in;
                overflow_q  <= 1'b0;
                underflow_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (valid_in) begin
                            acc_q   <= '0;
                            k_q     <= '0;
                            state_q <= S_MAC;
                        end
                    end
                    S_MAC: begin
                        acc_q     <= acc_d;
                        overrun_q <= valid_in;
                        if (k_q == AW'(H - 1)) begin
                            state_q <= S_ROUND;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                    S_ROUND: begin
                        fir_out_q   <= sat_val;
                        overflow_q  <= sat_hi;
                        underflow_q <= sat_lo;
                        valid_out_q <= 1'b1;
                        overrun_q   <= valid_in;
                        state_q     <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign fir_out   = fir_out_q;
    assign valid_out = valid_out_q;
    assign busy      = (state_q != S_IDLE);
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Bench for cic_comp_fir: random and directed samples scored against a direct-form convolution model
// holding the full tap history and the symmetric-expanded coefficient set.
module tb_cic_comp_fir;

    localparam int DW   = 16;
    localparam int CW   = 18;
    localparam int CF   = 16;
    localparam int TAPS = 7;
    localparam int H    = (TAPS + 1) / 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 valid_in, bypass, coeff_wr_en;
    logic signed [DW-1:0] fir_in;
    logic [1:0]           coeff_addr;
    logic signed [CW-1:0] coeff_data;
    logic signed [DW-1:0] fir_out;
    logic                 valid_out, busy, overflow, underflow, overrun;

    cic_comp_fir dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .bypass     (bypass),
        .fir_in     (fir_in),
        .coeff_wr_en(coeff_wr_en),
        .coeff_addr (coeff_addr),
        .coeff_data (coeff_data),
        .fir_out    (fir_out),
        .valid_out  (valid_out),
        .busy       (busy),
        .overflow   (overflow),
        .underflow  (underflow),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int     n_checks, n_errors;
    longint hist [TAPS];
    longint coef [H];
    int     imp_exp [TAPS];
    int     max_exp [TAPS];
    int     min_exp [TAPS];
    int     lat, seen;
    logic signed [DW-1:0] s, v1, v2, bv;
    bit     bvld;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < TAPS; i++) hist[i] = 0;
        coef = '{-2048, 4096, -8192, 77824};
    endfunction

    function automatic void model_push(input longint v);
        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = v;
    endfunction

    function automatic void model_eval(output longint y, output bit ov, output bit un);
        longint acc;
        acc = 0;
        for (int j = 0; j < TAPS; j++) acc += hist[j] * coef[(j < H) ? j : TAPS - 1 - j];
        y  = (acc + (64'sd1 <<< (CF - 1))) >>> CF;
        ov = (y > 32767);
        un = (y < -32768);
        if (ov) y = 32767;
        if (un) y = -32768;
    endfunction

    function automatic logic signed [DW-1:0] rand16();
        return 16'($urandom);
    endfunction

    task automatic drive_valid(input logic signed [DW-1:0] v);
        @(negedge clk);
        fir_in   = v;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic wait_valid(output int l);
        l = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (valid_out) begin
                l = i;
                break;
            end
        end
    endtask

    task automatic expect_output(input string tag);
        longint y;
        bit ov, un;
        model_eval(y, ov, un);
        check({tag, ".out"}, fir_out, y);
        check({tag, ".ovf"}, overflow, ov);
        check({tag, ".udf"}, underflow, un);
    endtask

    task automatic send_and_check(input logic signed [DW-1:0] v, input string tag);
        int l;
        drive_valid(v);
        model_push(v);
        check({tag, ".busy"}, busy, 1);
        wait_valid(l);
        check({tag, ".lat"}, l, H + 1);
        expect_output(tag);
        check({tag, ".idle"}, busy, 0);
        check({tag, ".ovr"}, overrun, 0);
    endtask

    task automatic write_coeff(input int a, input int d);
        @(negedge clk);
        coeff_wr_en = 1'b1;
        coeff_addr  = 2'(a);
        coeff_data  = 18'(d);
        @(negedge clk);
        coeff_wr_en = 1'b0;
        coef[a] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        valid_in = 0; bypass = 0; fir_in = 0;
        coeff_wr_en = 0; coeff_addr = 0; coeff_data = 0;
        imp_exp = '{-512, 1024, -2048, 19456, -2048, 1024, -512};
        max_exp = '{-1024, 2048, -4096, 32767, -4096, 2048, -1024};
        min_exp = '{1024, -2048, 4096, -32768, 4096, -2048, 1024};
        model_reset();
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.out", fir_out, 0);
        check("rst.vld", valid_out, 0);
        check("rst.busy", busy, 0);
        check("rst.flags", {overflow, underflow, overrun}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) send_and_check(16'sh4000, "dc");
        check("dc.final", fir_out, 16384);

        for (int i = 0; i < 7; i++) send_and_check(16'sh0, "flush");
        for (int i = 0; i < 7; i++) begin
            s = (i == 0) ? 16'sh4000 : 16'sh0;
            send_and_check(s, "imp");
            check("imp.tab", fir_out, imp_exp[i]);
        end
        for (int i = 0; i < 7; i++) begin
            s = (i == 0) ? 16'sh7FFF : 16'sh0;
            send_and_check(s, "max");
            check("max.tab", fir_out, max_exp[i]);
            check("max.ovf_tab", overflow, (i == 3) ? 1 : 0);
        end
        for (int i = 0; i < 7; i++) begin
            s = (i == 0) ? 16'sh8000 : 16'sh0;
            send_and_check(s, "min");
            check("min.tab", fir_out, min_exp[i]);
            check("min.udf_tab", underflow, (i == 3) ? 1 : 0);
        end

        for (int i = 0; i < 16; i++) send_and_check(rand16(), "rand");

        // Second sample on the very next cycle is dropped.
        v1 = rand16(); v2 = rand16();
        @(negedge clk); fir_in = v1; valid_in = 1'b1;
        @(negedge clk); fir_in = v2;
        @(negedge clk); valid_in = 1'b0;
        model_push(v1);
        check("b2b.ovr", overrun, 1);
        @(negedge clk);
        check("b2b.ovr_clr", overrun, 0);
        wait_valid(lat);
        check("b2b.lat", lat, 3);
        expect_output("b2b");

        // Sample arriving on the ROUND edge is dropped too.
        v1 = rand16(); v2 = rand16();
        drive_valid(v1);
        model_push(v1);
        repeat (4) @(negedge clk);
        fir_in = v2; valid_in = 1'b1;
        @(negedge clk); valid_in = 1'b0;
        check("rnd.vld", valid_out, 1);
        check("rnd.ovr", overrun, 1);
        expect_output("rnd");
        @(negedge clk);
        check("rnd.ovr_clr", overrun, 0);
        send_and_check(rand16(), "rnd.next");

        write_coeff(3, 65536);
        for (int a = 0; a < 3; a++) write_coeff(a, 0);
        for (int i = 0; i < 7; i++) send_and_check(16'sh0, "pflush");
        for (int i = 0; i < 7; i++) begin
            s = (i == 0) ? 16'sh1234 : 16'sh0;
            send_and_check(s, "pass");
            check("pass.tab", fir_out, (i == 3) ? 'h1234 : 0);
        end
        write_coeff(0, -2048);
        write_coeff(1, 4096);
        write_coeff(2, -8192);
        write_coeff(3, 77824);

        // Writes on the accept edge and during MAC must not land.
        v1 = rand16();
        @(negedge clk);
        fir_in = v1; valid_in = 1'b1;
        coeff_wr_en = 1'b1; coeff_addr = 2'd3; coeff_data = 18'sd0;
        @(negedge clk); valid_in = 1'b0;
        model_push(v1);
        @(negedge clk); coeff_wr_en = 1'b0;
        wait_valid(lat);
        check("wrbusy.lat", lat, 4);
        expect_output("wrbusy");
        for (int i = 0; i < 6; i++) send_and_check(rand16(), "wrbusy.dflt");

        v1 = rand16();
        drive_valid(v1);
        model_push(v1);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            bv   = (i < 4) ? rand16() : 16'sh4000;
            bvld = (i < 4) ? 1'($urandom_range(0, 1)) : 1'b1;
            bypass = 1'b1; fir_in = bv; valid_in = bvld;
            @(negedge clk);
            if (bvld) model_push(bv);
            check("byp.out", fir_out, bv);
            check("byp.vld", valid_out, bvld);
            check("byp.busy", busy, 0);
            check("byp.flags", {overflow, underflow, overrun}, 0);
        end
        bypass = 1'b0; valid_in = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (valid_out) seen++;
        end
        check("byp.abort", seen, 0);
        send_and_check(16'sh4000, "byp.exit");
        check("byp.dc", fir_out, 16384);

        drive_valid(rand16());
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst.out", fir_out, 0);
        check("mrst.vld", valid_out, 0);
        check("mrst.busy", busy, 0);
        check("mrst.flags", {overflow, underflow, overrun}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (valid_out) seen++;
        end
        check("mrst.novld", seen, 0);
        for (int i = 0; i < 4; i++) send_and_check(rand16(), "post_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
